moore_seq_tx: RTL and testbench

MOORE_SEQ_TX -- requirements
Module: moore_seq_tx

---
 rtl/moore_seq_tx.sv | 177 +++++++++++++++++
 tb/tb_moore_seq_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_tx.sv
// moore_seq_tx -- serial frame transmitter feeding a 1101 Moore detector.
//
// Each accepted payload is sent on x1_out as: preamble 1,1,0,1, then the
// payload MSB first, then two guard zeros. A zero is stuffed whenever the
// last three line bits are 1,1,0 and payload bits remain. This keeps 1101
// confined to the preamble, so the detector fires exactly once per frame.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   tx_valid   : payload offer from upstream
//   tx_data    : payload word, captured on acceptance
//   tx_ready   : high exactly when the transmitter is idle
//   x1_out     : registered serial line bit
//   busy       : registered, high for every bit of a frame
//   stuff      : registered, high while x1_out carries a stuffed zero
//   frame_done : registered pulse during the second guard cycle
module moore_seq_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              x1_out,
  output logic              busy,
  output logic              stuff,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DATA  = 3'd2,
    ST_STUFF = 3'd3,
    ST_GUARD = 3'd4
  } state_t;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        hist_q, hist_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              x1_q, x1_d;
  logic              busy_q, busy_d;
  logic              stuff_q, stuff_d;
  logic              done_q, done_d;

  // Preamble bit by position; position 0 is sent first.
  function automatic logic pre_bit(input logic [1:0] idx);
    logic b;
    case (idx)
      2'd0:    b = 1'b1;
      2'd1:    b = 1'b1;
      2'd2:    b = 1'b0;
      2'd3:    b = 1'b1;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Next state and the next line bit. Outputs are computed one cycle ahead,
  // so every output flop holds the bit belonging to the current state.
  // cnt meaning: PRE = next preamble index, DATA = payload bits already
  // sent, GUARD = guard cycles already sent minus one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    x1_d    = 1'b0;
    busy_d  = 1'b0;
    stuff_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d = ST_PRE;
          cnt_d   = 6'd1;
          data_d  = tx_data;
          x1_d    = pre_bit(2'd0);
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE: begin
        busy_d = 1'b1;
        if (cnt_q == 6'd4) begin
          state_d = ST_DATA;
          x1_d    = data_q[DATA_W-1];
          data_d  = data_q << 1'd1;
          cnt_d   = 6'd1;
        end else begin
          x1_d  = pre_bit(cnt_q[1:0]);
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DATA: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Last payload bit already on the line: no stuffing check.
          state_d = ST_GUARD;
          cnt_d   = 6'd0;
        end else if (hist_q == 3'b110) begin
          state_d = ST_STUFF;
          stuff_d = 1'b1;
        end else begin
          x1_d   = data_q[DATA_W-1];
          data_d = data_q << 1'd1;
          cnt_d  = cnt_q + 6'd1;
        end
      end
      ST_STUFF: begin
        // After a stuffed zero the history ends in 0,0, so no second stuff.
        busy_d  = 1'b1;
        state_d = ST_DATA;
        x1_d    = data_q[DATA_W-1];
        data_d  = data_q << 1'd1;
        cnt_d   = cnt_q + 6'd1;
      end
      ST_GUARD: begin
        if (cnt_q == 6'd0) begin
          busy_d = 1'b1;
          done_d = 1'b1;
          cnt_d  = 6'd1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 6'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 6'd0;
      end
    endcase

    // History tracks every bit put on the line during a frame.
    if (busy_d) begin
      hist_d = {hist_q[1:0], x1_d};
    end else begin
      hist_d = hist_q;
    end
  end

  // State and registered outputs; reset discards any frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      hist_q  <= 3'b000;
      data_q  <= '0;
      x1_q    <= 1'b0;
      busy_q  <= 1'b0;
      stuff_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
      data_q  <= data_d;
      x1_q    <= x1_d;
      busy_q  <= busy_d;
      stuff_q <= stuff_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready   = (state_q == ST_IDLE);
  assign x1_out     = x1_q;
  assign busy       = busy_q;
  assign stuff      = stuff_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_moore_seq_tx.sv
// Testbench for moore_seq_tx (DATA_W = 8). Expected line contents come from
// directed constants or from a list-based model of the framing rules.
module tb_moore_seq_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_ready, x1_out, busy, stuff, frame_done;

  int checks = 0;
  int failures = 0;

  // 1101 detector on the line: counts completed patterns.
  int       z1_count = 0;
  logic [3:0] win = 4'b0000;

  logic exp_x1[$];
  logic exp_st[$];

  moore_seq_tx #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .x1_out(x1_out), .busy(busy), .stuff(stuff),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Sample the line bit of the cycle that is ending at this edge.
  always @(posedge clk) begin
    win = {win[2:0], x1_out};
    if (win == 4'b1101) z1_count++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Model: preamble, payload MSB first with a 0 inserted before any payload
  // bit whose preceding three line bits are 1,1,0, then two guard zeros.
  task automatic build_model(input logic [W-1:0] p);
    int n;
    exp_x1.delete();
    exp_st.delete();
    exp_x1.push_back(1'b1); exp_x1.push_back(1'b1);
    exp_x1.push_back(1'b0); exp_x1.push_back(1'b1);
    repeat (4) exp_st.push_back(1'b0);
    for (int i = W - 1; i >= 0; i--) begin
      n = exp_x1.size();
      if (exp_x1[n-3] == 1'b1 && exp_x1[n-2] == 1'b1 && exp_x1[n-1] == 1'b0) begin
        exp_x1.push_back(1'b0);
        exp_st.push_back(1'b1);
      end
      exp_x1.push_back(p[i]);
      exp_st.push_back(1'b0);
    end
    repeat (2) begin
      exp_x1.push_back(1'b0);
      exp_st.push_back(1'b0);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s wait_idle: tx_ready=%b required 1 within 64 cycles", name, tx_ready);
    end
  endtask

  // One full frame. use_model=0 takes expectations from the line/stuff
  // constants (MSB = first busy cycle); otherwise from the model.
  task automatic test_frame(input logic [W-1:0] p, input bit use_model,
                            input logic [31:0] line_v, input logic [31:0] stuff_v,
                            input int len_v, input string name);
    int len, zstart;
    logic [4:0] got, expv;
    if (use_model) begin
      build_model(p);
    end else begin
      exp_x1.delete();
      exp_st.delete();
      for (int c = 0; c < len_v; c++) begin
        exp_x1.push_back(line_v[len_v-1-c]);
        exp_st.push_back(stuff_v[len_v-1-c]);
      end
    end
    len = exp_x1.size();
    wait_idle(name);
    tx_valid = 1'b1;
    tx_data  = p;
    @(negedge clk);
    zstart = z1_count;
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      got  = {busy, x1_out, stuff, frame_done, tx_ready};
      expv = {1'b1, exp_x1[c], exp_st[c], (c == len - 1), 1'b0};
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL %s cycle %0d: busy/x1/stuff/done/ready=%b required %b", name, c + 1, got, expv);
      end
      if (c == 4) begin
        checks++;
        if (z1_count !== zstart + 1) begin
          failures++;
          $display("FAIL %s z1_after_preamble: count delta %0d required 1", name, z1_count - zstart);
        end
      end
      // Offers while busy must be ignored.
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = W'($urandom);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    got = {busy, x1_out, stuff, frame_done, tx_ready};
    checks++;
    if (got !== 5'b00001) begin
      failures++;
      $display("FAIL %s idle_after: busy/x1/stuff/done/ready=%b required 00001", name, got);
    end
    checks++;
    if (z1_count !== zstart + 1) begin
      failures++;
      $display("FAIL %s z1_per_frame: count delta %0d required 1", name, z1_count - zstart);
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'hDD;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      got = {busy, x1_out, stuff, frame_done, tx_ready};
      checks++;
      if (got !== 5'b00001) begin
        failures++;
        $display("FAIL reset_hold %0d: busy/x1/stuff/done/ready=%b required 00001", k, got);
      end
    end
    tx_valid = 1'b0;
    #2 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got = {busy, x1_out, stuff, frame_done, tx_ready};
      checks++;
      if (got !== 5'b00001) begin
        failures++;
        $display("FAIL post_reset_idle %0d: busy/x1/stuff/done/ready=%b required 00001", k, got);
      end
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      test_frame(W'($urandom), 1'b1, 32'd0, 32'd0, 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic eb[$], ex[$], es[$], ed[$], er[$];
    int len1, len2, total, zstart;
    logic [4:0] got, expv;
    build_model(8'hDD);
    len1 = exp_x1.size();
    for (int c = 0; c < len1; c++) begin
      eb.push_back(1'b1); ex.push_back(exp_x1[c]); es.push_back(exp_st[c]);
      ed.push_back(c == len1 - 1); er.push_back(1'b0);
    end
    eb.push_back(1'b0); ex.push_back(1'b0); es.push_back(1'b0);
    ed.push_back(1'b0); er.push_back(1'b1);
    build_model(8'h00);
    len2 = exp_x1.size();
    for (int c = 0; c < len2; c++) begin
      eb.push_back(1'b1); ex.push_back(exp_x1[c]); es.push_back(exp_st[c]);
      ed.push_back(c == len2 - 1); er.push_back(1'b0);
    end
    eb.push_back(1'b0); ex.push_back(1'b0); es.push_back(1'b0);
    ed.push_back(1'b0); er.push_back(1'b1);
    total = eb.size();
    wait_idle("b2b");
    zstart = z1_count;
    tx_valid = 1'b1;
    tx_data = 8'hDD;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      got  = {busy, x1_out, stuff, frame_done, tx_ready};
      expv = {eb[c], ex[c], es[c], ed[c], er[c]};
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL b2b cycle %0d: busy/x1/stuff/done/ready=%b required %b", c + 1, got, expv);
      end
      if (c < len1 - 1) tx_data = W'($urandom);
      else if (c <= len1) tx_data = 8'h00;
      else tx_data = W'($urandom);
      if (c >= len1 + len2 - 1) tx_valid = 1'b0;
    end
    checks++;
    if (z1_count !== zstart + 2) begin
      failures++;
      $display("FAIL b2b z1_count: delta %0d required 2", z1_count - zstart);
    end
  endtask

  task automatic test_reset_midframe();
    logic [4:0] got;
    wait_idle("rst_mid");
    tx_valid = 1'b1;
    tx_data = W'($urandom);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid busy_before: busy=%b required 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    got = {busy, x1_out, stuff, frame_done, tx_ready};
    checks++;
    if (got !== 5'b00001) begin
      failures++;
      $display("FAIL rst_mid async: busy/x1/stuff/done/ready=%b required 00001", got);
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    // Offer right after release: accepted at the first rising edge.
    test_frame(8'hB6, 1'b1, 32'd0, 32'd0, 0, "fresh_after_rst");
  endtask

  initial begin
    test_reset();
    test_frame(8'h00, 1'b0, 32'h0000_3400, 32'h0000_0000, 14, "payload_00");
    test_frame(8'hDD, 1'b0, 32'h0000_DCE4, 32'h0000_0108, 16, "payload_DD");
    test_frame(8'h06, 1'b0, 32'h0000_3418, 32'h0000_0000, 14, "payload_06");
    test_frame(8'hFF, 1'b1, 32'd0, 32'd0, 0, "payload_FF");
    test_frame(8'h6D, 1'b1, 32'd0, 32'd0, 0, "payload_6D");
    test_random(25);
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
